countdown_ctrl: RTL and testbench

//  Control end of the cascaded countdown-digit chain. Each digit counter takes set/carry_in and returns carry_out.

---
 rtl/countdown_ctrl.sv | 139 +++++++++++++
 tb/tb_countdown_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: control end of the cascaded countdown-digit chain.
// Generates the per-second tick, the preset set pulse, and sequences
// start/pause/load; detects expiry from the top digit borrow.
// Ports: clk, rst (sync, active-high), start/pause/load (1-cycle pulses),
//   chain_borrow (top-digit carry_out), tick, set, running, done, alarm,
//   state[1:0] (IDLE=0, RUN=1, PAUSE=2, DONE=3).
// Optional: define ALARM_BLINK_EN to blink alarm in DONE every BLINK_DIV cycles.
module countdown_ctrl #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned PRE_WIDTH = 32,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic       chain_borrow,
  output logic       tick,
  output logic       set,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [PRE_WIDTH-1:0] PreTop = PRE_WIDTH'(TICK_DIV - 1);

  state_e               state_q, state_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic                 set_q, set_d;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    set_d   = 1'b0;
    // pause/load on the wrap cycle suppress the tick (and any expiry)
    tick = (state_q == RUN) && (pre_q == PreTop) && !pause && !load;
    if (load) begin
      set_d = 1'b1;
      pre_d = '0;
    end
    case (state_q)
      IDLE: begin
        if (!load && start) state_d = RUN;
      end
      RUN: begin
        if (load) begin
          state_d = RUN;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          pre_d = '0;
          if (chain_borrow) begin
            // chain just wrapped to max; set pulse restores the preset
            state_d = DONE;
            set_d   = 1'b1;
          end
        end else begin
          pre_d = pre_q + PRE_WIDTH'(1);
        end
      end
      PAUSE: begin
        if (load) state_d = IDLE;
        else if (start) state_d = RUN;
      end
      DONE: begin
        if (load) state_d = IDLE;
        else if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      set_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      set_q   <= set_d;
    end
  end

  assign set     = set_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign state   = state_q;

`ifdef ALARM_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BlkTop = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blk_q, blk_d;
  logic          alarm_q, alarm_d;

  always_comb begin
    blk_d   = '0;
    alarm_d = 1'b0;
    if (state_d == DONE) begin
      if (state_q != DONE) begin
        alarm_d = 1'b1;
      end else if (blk_q == BlkTop) begin
        alarm_d = !alarm_q;
      end else begin
        blk_d   = blk_q + BW'(1);
        alarm_d = alarm_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      blk_q   <= blk_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  // blink divider is not built; the empty block only consumes the parameter
  if (BLINK_DIV == 0) begin : g_no_blink
  end
  assign alarm = done;
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed bench for countdown_ctrl with a 2-digit
// chain model (MIN=0, MAX=9, preset 01), TICK_DIV=4, BLINK_DIV=3.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic       chain_borrow;
  logic       tick, set, running, done, alarm;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  countdown_ctrl #(
    .TICK_DIV (4),
    .PRE_WIDTH(8),
    .BLINK_DIV(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .load        (load),
    .chain_borrow(chain_borrow),
    .tick        (tick),
    .set         (set),
    .running     (running),
    .done        (done),
    .alarm       (alarm),
    .state       (state)
  );

  always #5 clk = ~clk;

  // two-digit down-counting chain, preset 01
  logic [3:0] dt, du;
  always @(posedge clk) begin
    if (rst || set) begin
      dt <= 4'd0;
      du <= 4'd1;
    end else if (tick) begin
      if (du == 4'd0) begin
        du <= 4'd9;
        dt <= (dt == 4'd0) ? 4'd9 : dt - 4'd1;
      end else begin
        du <= du - 4'd1;
      end
    end
  end
  // deliberately not gated by tick: the controller must ignore it
  assign chain_borrow = (dt == 4'd0) && (du == 4'd0);

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];

  wire [6:0] obs = {tick, set, state, running, done, alarm};

  task automatic cyc(input string tag, input logic r, input logic st,
                     input logic pa, input logic ld, input logic et,
                     input logic es, input logic [1:0] est,
                     input logic ea);
    exp_t e;
    logic al;
    rst   = r;
    start = st;
    pause = pa;
    load  = ld;
`ifdef ALARM_BLINK_EN
    al = ea;
`else
    al = (est == 2'd3);
`endif
    e.tag = tag;
    e.v   = {et, es, est, est == 2'd1, est == 2'd3, al};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", e.tag, obs, e.v);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    load  = 1'b0;
  endtask

  task automatic chk_chain(input string tag, input logic [7:0] ev);
    checks++;
    assert ({dt, du} === ev) else begin
      errors++;
      $error("FAIL %s chain=%h exp=%h", tag, {dt, du}, ev);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // args: tag, rst, start, pause, load | tick, set, state, alarm
    repeat (10) cyc("idle", 0, 0, 0, 0, 0, 0, 2'd0, 0);
    cyc("ld", 0, 0, 0, 1, 0, 0, 2'd0, 0);
    cyc("ld_set", 0, 0, 0, 0, 0, 1, 2'd0, 0);
    chk_chain("chain_ld", 8'h01);
    cyc("start", 0, 1, 0, 0, 0, 0, 2'd0, 0);
    cyc("r0", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("r1", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("r2", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("tick1", 0, 0, 0, 0, 1, 0, 2'd1, 0);
    chk_chain("chain_t1", 8'h00);
    cyc("r0b", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("r1b", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("r2b", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("tick2", 0, 0, 0, 0, 1, 0, 2'd1, 0);
    chk_chain("chain_wrap", 8'h99);
    cyc("dn1", 0, 0, 1, 0, 0, 1, 2'd3, 1);
    chk_chain("chain_rel", 8'h01);
    cyc("dn2", 0, 0, 0, 0, 0, 0, 2'd3, 1);
    cyc("dn3", 0, 0, 0, 0, 0, 0, 2'd3, 1);
    cyc("dn4", 0, 0, 0, 0, 0, 0, 2'd3, 0);
    cyc("dn5", 0, 0, 0, 0, 0, 0, 2'd3, 0);
    cyc("dn6", 0, 0, 0, 0, 0, 0, 2'd3, 0);
    cyc("dn7", 0, 1, 0, 0, 0, 0, 2'd3, 1);
    cyc("rs0", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("rs1", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("ps", 0, 0, 1, 0, 0, 0, 2'd1, 0);
    repeat (10) cyc("hold", 0, 0, 0, 0, 0, 0, 2'd2, 0);
    cyc("resume", 0, 1, 0, 0, 0, 0, 2'd2, 0);
    cyc("rm2", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("rm_tick", 0, 0, 0, 0, 1, 0, 2'd1, 0);
    chk_chain("chain_rm", 8'h00);
    cyc("q0", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("q1", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("q2", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("pz_tick", 0, 0, 1, 0, 0, 0, 2'd1, 0);
    cyc("pz", 0, 0, 1, 0, 0, 0, 2'd2, 0);
    chk_chain("chain_pz", 8'h00);
    cyc("pz_go", 0, 1, 0, 0, 0, 0, 2'd2, 0);
    cyc("held_tick", 0, 0, 0, 0, 1, 0, 2'd1, 0);
    cyc("dn_b", 0, 0, 0, 1, 0, 1, 2'd3, 1);
    cyc("to_idle", 0, 0, 0, 0, 0, 1, 2'd0, 0);
    chk_chain("chain_idle", 8'h01);
    cyc("idle_pz", 0, 0, 1, 0, 0, 0, 2'd0, 0);
    cyc("idle_chk", 0, 0, 0, 0, 0, 0, 2'd0, 0);
    cyc("st2", 0, 1, 0, 0, 0, 0, 2'd0, 0);
    cyc("s0", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("s1", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("s2", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("ld_tick", 0, 0, 0, 1, 0, 0, 2'd1, 0);
    cyc("ld_run", 0, 0, 0, 0, 0, 1, 2'd1, 0);
    chk_chain("chain_ldrun", 8'h01);
    cyc("lr1", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("rst_mid", 1, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("rst_idle", 0, 0, 0, 0, 0, 0, 2'd0, 0);
    cyc("rst_st", 0, 1, 0, 0, 0, 0, 2'd0, 0);
    cyc("t0", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("t1", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("t2", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("rst_tick", 0, 0, 0, 0, 1, 0, 2'd1, 0);
    cyc("no_done", 0, 0, 0, 0, 0, 0, 2'd1, 0);
    cyc("p_in", 0, 0, 1, 0, 0, 0, 2'd1, 0);
    cyc("p_ld", 0, 0, 0, 1, 0, 0, 2'd2, 0);
    cyc("p_idle", 0, 0, 0, 0, 0, 1, 2'd0, 0);
    cyc("prio", 0, 1, 0, 1, 0, 0, 2'd0, 0);
    cyc("prio_n", 0, 0, 0, 0, 0, 1, 2'd0, 0);
    cyc("prio_z", 0, 0, 0, 0, 0, 0, 2'd0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
